// File: rtl/reg_bank_ctrl.sv
// Register-bank controller: sel/wr/ready bus slave with byte strobes, per-register
// read-only / write-1-to-clear modes, configurable read wait states and error response.
module reg_bank_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 'h1234,
    parameter int                    RD_WAIT    = 1,
    parameter logic [DEPTH-1:0]      RO_MASK    = '0,
    parameter logic [DEPTH-1:0]      W1C_MASK   = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sel,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_oor;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_ro;
    logic                  w_w1c;
    logic                  w_wr_req;
    logic                  w_wr_err;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic                  w_ready;
    logic                  w_err;

    assign w_oor    = {1'b0, addr} >= (ADDR_WIDTH+1)'(DEPTH);
    assign w_idx    = addr[IDX_W-1:0];
    assign w_ro     = !w_oor && RO_MASK[w_idx];
    assign w_w1c    = W1C_MASK[w_idx] && !RO_MASK[w_idx];
    assign w_rd_val = w_oor ? '0 : r_mem[w_idx];
    assign w_wr_req = (r_state == IDLE) && sel && wr;
    assign w_wr_err = w_oor || w_ro;
    assign w_wr_en  = w_wr_req && !w_wr_err;

    // ready/err are decoded from state so a write completes at the same edge it is issued
    always_comb begin
        w_ready = 1'b1;
        w_err   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = !(sel && !wr);
                w_err   = sel && wr && w_wr_err && (strb != '0);
            end
            WAIT: w_ready = 1'b0;
            RESP: w_err = sel && w_oor;
            default: w_ready = 1'b1;
        endcase
    end

    assign ready = w_ready;
    assign err   = w_err;
    assign rdata = r_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sel && !wr) begin
                        if (RD_WAIT > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(RD_WAIT - 1);
                        end else begin
                            r_state <= RESP;
                            r_rdata <= w_rd_val;
                        end
                    end
                end
                WAIT: begin
                    if (!sel) begin
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_rdata <= w_rd_val;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (w_wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (strb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_w1c ? (r_mem[w_idx][8*b +: 8] & ~wdata[8*b +: 8])
                                                    : wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl: directed plan steps plus randomized traffic against an array model.
module tb_reg_bank_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    logic [1:0]  tgt;

    logic [15:0] rdata_0, rdata_1, rdata_3;
    logic        ready_0, ready_1, ready_3;
    logic        err_0, err_1, err_3;
    logic        sel_0, sel_1, sel_3;
    logic [15:0] rdata_m;
    logic        ready_m, err_m;

    int passed = 0;
    int total  = 0;

    logic [15:0] model [16];

    always #5 clk = ~clk;

    assign sel_0 = sel && (tgt == 2'd0);
    assign sel_1 = sel && (tgt == 2'd1);
    assign sel_3 = sel && (tgt == 2'd3);
    assign rdata_m = (tgt == 2'd0) ? rdata_0 : (tgt == 2'd3) ? rdata_3 : rdata_1;
    assign ready_m = (tgt == 2'd0) ? ready_0 : (tgt == 2'd3) ? ready_3 : ready_1;
    assign err_m   = (tgt == 2'd0) ? err_0   : (tgt == 2'd3) ? err_3   : err_1;

    reg_bank_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(16), .RESET_VAL(16'h1234),
                    .RD_WAIT(1), .RO_MASK(16'h0008), .W1C_MASK(16'h0004)) dut (
        .clk(clk), .rstn(rstn), .sel(sel_1), .wr(wr), .addr(addr), .wdata(wdata),
        .strb(strb), .rdata(rdata_1), .ready(ready_1), .err(err_1));

    reg_bank_ctrl #(.RD_WAIT(0)) dut_w0 (
        .clk(clk), .rstn(rstn), .sel(sel_0), .wr(wr), .addr(addr), .wdata(wdata),
        .strb(strb), .rdata(rdata_0), .ready(ready_0), .err(err_0));

    reg_bank_ctrl #(.RD_WAIT(3)) dut_w3 (
        .clk(clk), .rstn(rstn), .sel(sel_3), .wr(wr), .addr(addr), .wdata(wdata),
        .strb(strb), .rdata(rdata_3), .ready(ready_3), .err(err_3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 16'h1234;
    endtask

    // Applies a write to the model and returns the error response it should produce
    task automatic model_write(input int a, input logic [15:0] d, input logic [1:0] s,
                               output logic e);
        logic [7:0] cur, nb;
        e = 1'b0;
        if (a >= 16 || a == 3) begin
            e = (s != 2'b00);
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (s[b]) begin
                    cur = model[a][8*b +: 8];
                    nb  = d[8*b +: 8];
                    model[a][8*b +: 8] = (a == 2) ? (cur & ~nb) : nb;
                end
            end
        end
    endtask

    task automatic do_write(input int a, input logic [15:0] d, input logic [1:0] s);
        logic e;
        model_write(a, d, s, e);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; addr = 8'(a); wdata = d; strb = s;
        #1;
        check("wr_ready", 32'(ready_m), 32'd1);
        check("wr_err", 32'(err_m), 32'(e));
        @(posedge clk);
    endtask

    task automatic do_read(input int a, output logic [15:0] d, output logic e, output int lows);
        bit got = 0;
        lows = 0;
        d = 'x; e = 1'bx;
        @(negedge clk);
        sel = 1'b1; wr = 1'b0; addr = 8'(a);
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (ready_m === 1'b1) got = 1;
            else begin
                lows++;
                @(negedge clk);
            end
        end
        if (got) begin
            d = rdata_m;
            e = err_m;
            @(posedge clk);
        end else begin
            check("rd_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        sel = 1'b0; wr = 1'b0;
    endtask

    logic [15:0] d, prev;
    logic        e;
    int          lows;
    int          a;
    logic [15:0] wd;
    logic [1:0]  ws;

    initial begin
        rstn = 1'b0; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0; strb = '0; tgt = 2'd1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_1), 32'd1);
        check("rst_err", 32'(err_1), 32'd0);
        check("rst_rdata", 32'(rdata_1), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        do_read(0, d, e, lows);
        check("rst_rd0", 32'(d), 32'h1234); check("rst_rd0_err", 32'(e), 0);
        check("rst_rd0_lat", 32'(lows), 32'd2);
        do_read(15, d, e, lows);
        check("rst_rd15", 32'(d), 32'h1234); check("rst_rd15_err", 32'(e), 0);
        check("rst_rd15_lat", 32'(lows), 32'd2);

        do_write(5, 16'hABCD, 2'b10);
        do_read(5, d, e, lows);
        check("strb_hi", 32'(d), 32'hAB34);
        do_write(5, 16'h00EF, 2'b01);
        do_read(5, d, e, lows);
        check("strb_lo", 32'(d), 32'hABEF);

        do_write(2, 16'h0204, 2'b11);
        do_read(2, d, e, lows);
        check("w1c", 32'(d), 32'h1030); check("w1c_err", 32'(e), 0);
        do_read(2, d, e, lows);
        check("w1c_read_nomod", 32'(d), 32'h1030);
        do_write(3, 16'hFFFF, 2'b11);
        do_read(3, d, e, lows);
        check("ro", 32'(d), 32'h1234);

        do_write(20, 16'h5555, 2'b11);
        do_read(20, d, e, lows);
        check("oor_rd", 32'(d), 32'h0); check("oor_rd_err", 32'(e), 32'd1);

        for (int k = 0; k < 8; k++) do_write(8 + k, 16'(16'h1111 * k), 2'b11);
        bus_idle();

        for (int k = 0; k < 16; k++) begin
            do_read(k, d, e, lows);
            check("sweep_rd", 32'(d), 32'(model[k]));
        end

        for (int k = 0; k < 80; k++) begin
            a  = $urandom_range(0, 19);
            wd = 16'($urandom);
            ws = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, wd, ws);
            end else begin
                do_read(a, d, e, lows);
                check("rand_rd", 32'(d), (a >= 16) ? 32'd0 : 32'(model[a]));
                check("rand_err", 32'(e), (a >= 16) ? 32'd1 : 32'd0);
                check("rand_lat", 32'(lows), 32'd2);
            end
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();

        tgt = 2'd0;
        do_read(4, d, e, lows);
        check("lat_w0", 32'(lows), 32'd1); check("lat_w0_rd", 32'(d), 32'h1234);
        bus_idle();
        tgt = 2'd3;
        do_read(9, d, e, lows);
        check("lat_w3", 32'(lows), 32'd4); check("lat_w3_rd", 32'(d), 32'h1234);
        bus_idle();
        tgt = 2'd1;

        prev = rdata_1;
        @(negedge clk);
        sel = 1'b1; wr = 1'b0; addr = 8'd2;
        @(negedge clk);
        sel = 1'b0;
        @(posedge clk); #1;
        check("abort_rdata", 32'(rdata_1), 32'(prev));
        check("abort_ready", 32'(ready_1), 32'd1);

        @(negedge clk);
        sel = 1'b1; wr = 1'b0; addr = 8'd7;
        @(negedge clk);
        check("mid_wait", 32'(ready_1), 32'd0);
        rstn = 1'b0;
        model_reset();
        sel = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready_1), 32'd1);
        check("mid_rst_rdata", 32'(rdata_1), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        do_read(7, d, e, lows);
        check("mid_rst_rd", 32'(d), 32'(model[7]));
        check("mid_rst_lat", 32'(lows), 32'd2);
        do_read(2, d, e, lows);
        check("mid_rst_w1c", 32'(d), 32'h1234);
        bus_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
